multi_channel_signal_shifter: RTL and testbench

//  NUM_CH independent edge-counting delayed-pulse generators.
//  Per channel: count N qualifying edges on an async input, wait D clk cycles, emit a W-cycle pulse, re-arm.

---
 rtl/multi_channel_signal_shifter_pkg.sv | 10 +
 rtl/multi_channel_signal_shifter_if.sv | 15 +
 rtl/multi_channel_signal_shifter_channel.sv | 139 +++++++++++++
 rtl/multi_channel_signal_shifter.sv | 51 +++++
 tb/tb_multi_channel_signal_shifter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_channel_signal_shifter_pkg.sv
// signal_shifter_pkg: channel state type, register map and CTRL bit positions
package signal_shifter_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DELAY, PULSE} ch_state_t;
  localparam logic [1:0] REG_DELAY = 2'd0;
  localparam logic [1:0] REG_EVENT = 2'd1;
  localparam logic [1:0] REG_WIDTH = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_POL = 1;
endpackage

// File: rtl/multi_channel_signal_shifter_if.sv
// multi_channel_signal_shifter_if: register write port
//   cfg_we   one-cycle write strobe
//   cfg_ch   target channel
//   cfg_addr register select (DELAY/EVENT/WIDTH/CTRL)
//   cfg_data LSB-aligned write data
interface multi_channel_signal_shifter_if #(
  parameter int CH_W = 2
);
  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [1:0]      cfg_addr;
  logic [31:0]     cfg_data;
  modport master (output cfg_we, cfg_ch, cfg_addr, cfg_data);
  modport slave  (input  cfg_we, cfg_ch, cfg_addr, cfg_data);
endinterface

// File: rtl/multi_channel_signal_shifter_channel.sv
// signal_shifter_channel: one edge-counting delayed-pulse generator
//   clk, reset    clock, synchronous active-high reset
//   trig_i        asynchronous trigger input
//   we_i          write strobe already decoded for this channel
//   addr_i/data_i register select and write data
//   pulse_o       output pulse (high while in PULSE)
//   busy_o        high while in DELAY or PULSE
//   miss_o        saturating missed-edge count (SHIFTER_MISS_CNT_EN only)
module signal_shifter_channel
  import signal_shifter_pkg::*;
#(
  parameter int MAX_DELAY = 10000000,
  parameter int MAX_EVENT = 1023,
  parameter int MAX_WIDTH = 65535,
  parameter int MISS_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic        pulse_o,
  output logic        busy_o
`ifdef SHIFTER_MISS_CNT_EN
  ,
  output logic [MISS_W-1:0] miss_o
`endif
);
  localparam int DELAY_W = $clog2(MAX_DELAY + 1);
  localparam int EVENT_W = $clog2(MAX_EVENT + 1);
  localparam int WIDTH_W = $clog2(MAX_WIDTH + 1);
  logic [DELAY_W-1:0] delay_q, delay_d, dly_sh_q, dly_sh_d, dly_cnt_q, dly_cnt_d;
  logic [EVENT_W-1:0] event_q, event_d, ev_cnt_q, ev_cnt_d, n_eff;
  logic [WIDTH_W-1:0] width_q, width_d, wid_sh_q, wid_sh_d, pw_cnt_q, pw_cnt_d;
  logic [1:0]         ctrl_q, ctrl_d, sync_q;
  logic               hist_q, edge_w, fire;
  ch_state_t          state_q, state_d;
  logic               unused_data;
  assign unused_data = ^data_i[31:DELAY_W];
  always_comb begin
    delay_d = (we_i && addr_i == REG_DELAY) ? data_i[DELAY_W-1:0] : delay_q;
    event_d = (we_i && addr_i == REG_EVENT) ? data_i[EVENT_W-1:0] : event_q;
    width_d = (we_i && addr_i == REG_WIDTH) ? data_i[WIDTH_W-1:0] : width_q;
    ctrl_d  = (we_i && addr_i == REG_CTRL)  ? data_i[1:0]         : ctrl_q;
  end
  // hist always follows the synced value, so a polarity change never fabricates an edge
  assign edge_w = (sync_q[1] != hist_q) && (sync_q[1] == ~ctrl_q[CTRL_POL]);
  assign n_eff  = (event_q == '0) ? EVENT_W'(1) : event_q;
  // >= rather than == so lowering EVENT below the running count fires on the next edge
  assign fire   = edge_w && (ev_cnt_q >= n_eff - EVENT_W'(1));
  always_comb begin
    state_d   = state_q;
    ev_cnt_d  = ev_cnt_q;
    dly_cnt_d = dly_cnt_q;
    pw_cnt_d  = pw_cnt_q;
    dly_sh_d  = dly_sh_q;
    wid_sh_d  = wid_sh_q;
    case (state_q)
      IDLE: begin
        ev_cnt_d  = '0;
        dly_cnt_d = '0;
        pw_cnt_d  = '0;
        state_d   = ctrl_q[CTRL_EN] ? COUNT : IDLE;
      end
      COUNT: begin
        if (fire) begin
          state_d   = DELAY;
          ev_cnt_d  = n_eff;
          dly_cnt_d = '0;
          dly_sh_d  = delay_q;
          wid_sh_d  = (width_q == '0) ? WIDTH_W'(1) : width_q;
        end else if (edge_w) begin
          ev_cnt_d = ev_cnt_q + EVENT_W'(1);
        end
      end
      DELAY: begin
        if (dly_cnt_q >= dly_sh_q) begin
          state_d  = PULSE;
          pw_cnt_d = WIDTH_W'(1);
        end else begin
          dly_cnt_d = dly_cnt_q + DELAY_W'(1);
        end
      end
      PULSE: begin
        if (pw_cnt_q >= wid_sh_q) begin
          state_d  = COUNT;
          ev_cnt_d = '0;
        end else begin
          pw_cnt_d = pw_cnt_q + WIDTH_W'(1);
        end
      end
    endcase
    // disable acts on the incoming CTRL value so a running pulse is cut on the next cycle
    if (!ctrl_d[CTRL_EN]) begin
      state_d  = IDLE;
      ev_cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_q   <= '0;
      event_q   <= EVENT_W'(1);
      width_q   <= WIDTH_W'(1);
      ctrl_q    <= '0;
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= IDLE;
      ev_cnt_q  <= '0;
      dly_cnt_q <= '0;
      pw_cnt_q  <= '0;
      dly_sh_q  <= '0;
      wid_sh_q  <= '0;
    end else begin
      delay_q   <= delay_d;
      event_q   <= event_d;
      width_q   <= width_d;
      ctrl_q    <= ctrl_d;
      sync_q    <= {sync_q[0], trig_i};
      hist_q    <= sync_q[1];
      state_q   <= state_d;
      ev_cnt_q  <= ev_cnt_d;
      dly_cnt_q <= dly_cnt_d;
      pw_cnt_q  <= pw_cnt_d;
      dly_sh_q  <= dly_sh_d;
      wid_sh_q  <= wid_sh_d;
    end
  end
  assign pulse_o = state_q == PULSE;
  assign busy_o  = (state_q == DELAY) || (state_q == PULSE);
`ifdef SHIFTER_MISS_CNT_EN
  logic [MISS_W-1:0] miss_q, miss_d;
  always_comb
    miss_d = (we_i && addr_i == REG_CTRL) ? '0 :
             (edge_w && busy_o && ~&miss_q) ? miss_q + MISS_W'(1) : miss_q;
  always_ff @(posedge clk) miss_q <= reset ? '0 : miss_d;
  assign miss_o = miss_q;
`endif
endmodule

// File: rtl/multi_channel_signal_shifter.sv
// multi_channel_signal_shifter: NUM_CH independent edge-counting delayed-pulse generators
//   clk, reset  clock, synchronous active-high reset
//   trig_in     asynchronous trigger inputs, one per channel
//   cfg         register write port (slave side)
//   out_pulse   per-channel output pulses
//   busy        per-channel DELAY/PULSE indication
//   miss_cnt    per-channel missed-edge counters, ch0 in LSBs
//               (present only when SHIFTER_MISS_CNT_EN is defined)
module multi_channel_signal_shifter
  import signal_shifter_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_DELAY = 10000000,
  parameter int MAX_EVENT = 1023,
  parameter int MAX_WIDTH = 65535,
  parameter int MISS_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       trig_in,
  multi_channel_signal_shifter_if.slave cfg,
  output logic [NUM_CH-1:0]       out_pulse,
  output logic [NUM_CH-1:0]       busy
`ifdef SHIFTER_MISS_CNT_EN
  ,
  output logic [NUM_CH*MISS_W-1:0] miss_cnt
`endif
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    signal_shifter_channel #(
      .MAX_DELAY (MAX_DELAY),
      .MAX_EVENT (MAX_EVENT),
      .MAX_WIDTH (MAX_WIDTH),
      .MISS_W    (MISS_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .trig_i  (trig_in[c]),
      .we_i    (cfg.cfg_we && cfg.cfg_ch == CH_W'(c)),
      .addr_i  (cfg.cfg_addr),
      .data_i  (cfg.cfg_data),
      .pulse_o (out_pulse[c]),
      .busy_o  (busy[c])
`ifdef SHIFTER_MISS_CNT_EN
      ,
      .miss_o  (miss_cnt[c*MISS_W +: MISS_W])
`endif
    );
  end
endmodule

// File: tb/tb_multi_channel_signal_shifter.sv
// tb_multi_channel_signal_shifter: directed and random checks against a timeline model
module tb_multi_channel_signal_shifter;
  import signal_shifter_pkg::*;
  localparam int NUM_CH = 4;
  localparam int MISS_W = 16;
  localparam int INF    = 1 << 30;
  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0] trig_in, out_pulse, busy;
`ifdef SHIFTER_MISS_CNT_EN
  logic [NUM_CH*MISS_W-1:0] miss_cnt;
`endif
  multi_channel_signal_shifter_if #(.CH_W(2)) cfg ();
  multi_channel_signal_shifter #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset), .trig_in(trig_in), .cfg(cfg),
    .out_pulse(out_pulse), .busy(busy)
`ifdef SHIFTER_MISS_CNT_EN
    , .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;
  int vectors = 0, errors = 0, cyc = 0;
  bit m_valid = 0;
  int m_dly[NUM_CH], m_evt[NUM_CH], m_wid[NUM_CH], m_cnt[NUM_CH], m_arm[NUM_CH];
  int m_bs[NUM_CH], m_ps[NUM_CH], m_pe[NUM_CH], m_miss[NUM_CH];
  logic [NUM_CH-1:0] m_en, m_pol, h0, h1, h2;
  // Timeline model: a counted Nth edge sampled at cycle t books busy [t+2, t+3+D+W)
  // and pulse [t+3+D, t+3+D+W); counting resumes when the pulse window ends.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_dly[i] = 0; m_evt[i] = 1; m_wid[i] = 1; m_cnt[i] = 0; m_arm[i] = INF;
        m_bs[i] = 0; m_ps[i] = 0; m_pe[i] = 0; m_miss[i] = 0;
      end
      m_en = '0; m_pol = '0; h0 = '0; h1 = '0; h2 = '0;
      m_valid = 1;
    end else if (m_valid) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bit e, bz;
        int c1;
        c1 = cyc - 1;
        e  = (h1[i] != h2[i]) && (h1[i] == !m_pol[i]);
        bz = (m_bs[i] <= c1) && (c1 < m_pe[i]);
        if (e && m_en[i] && c1 >= m_arm[i] && !bz) begin
          m_cnt[i]++;
          if (m_cnt[i] >= (m_evt[i] == 0 ? 1 : m_evt[i])) begin
            m_bs[i]  = cyc;
            m_ps[i]  = cyc + 1 + m_dly[i];
            m_pe[i]  = m_ps[i] + (m_wid[i] == 0 ? 1 : m_wid[i]);
            m_arm[i] = m_pe[i];
            m_cnt[i] = 0;
          end
        end else if (e && bz && m_miss[i] < (1 << MISS_W) - 1) m_miss[i]++;
        h2[i] = h1[i]; h1[i] = h0[i]; h0[i] = trig_in[i];
        if (cfg.cfg_we && cfg.cfg_ch == i) begin
          case (cfg.cfg_addr)
            REG_DELAY: m_dly[i] = int'(cfg.cfg_data & 32'h00FF_FFFF);
            REG_EVENT: m_evt[i] = int'(cfg.cfg_data & 32'h0000_03FF);
            REG_WIDTH: m_wid[i] = int'(cfg.cfg_data & 32'h0000_FFFF);
            default: begin
              m_miss[i] = 0;
              if (!cfg.cfg_data[0]) begin
                m_arm[i] = INF; m_cnt[i] = 0;
                if (m_pe[i] > cyc) m_pe[i] = cyc;
              end else if (!m_en[i]) m_arm[i] = cyc + 1;
              m_en[i] = cfg.cfg_data[0]; m_pol[i] = cfg.cfg_data[1];
            end
          endcase
        end
      end
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      logic [NUM_CH-1:0] ep, eb;
      for (int i = 0; i < NUM_CH; i++) begin
        ep[i] = (m_ps[i] <= cyc) && (cyc < m_pe[i]);
        eb[i] = (m_bs[i] <= cyc) && (cyc < m_pe[i]);
      end
      vectors++;
      if (out_pulse !== ep || busy !== eb) begin
        errors++;
        $display("FAIL model cyc=%0d out_pulse=%b busy=%b expected out_pulse=%b busy=%b", cyc, out_pulse, busy, ep, eb);
      end
`ifdef SHIFTER_MISS_CNT_EN
      for (int i = 0; i < NUM_CH; i++) begin
        vectors++;
        if (int'(miss_cnt[i*MISS_W +: MISS_W]) != m_miss[i]) begin
          errors++;
          $display("FAIL miss_model cyc=%0d ch=%0d got %0d expected %0d", cyc, i, miss_cnt[i*MISS_W +: MISS_W], m_miss[i]);
        end
      end
`endif
    end
  end
  task automatic chk(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(int ch, logic [1:0] a, int d);
    cfg.cfg_we = 1'b1; cfg.cfg_ch = 2'(ch); cfg.cfg_addr = a; cfg.cfg_data = 32'(d);
    @(negedge clk);
    cfg.cfg_we = 1'b0;
  endtask
  task automatic setup(int ch, int n, int d, int w, int ctrl);
    wr(ch, REG_EVENT, n); wr(ch, REG_DELAY, d); wr(ch, REG_WIDTH, w); wr(ch, REG_CTRL, ctrl);
  endtask
  task automatic wait_rise(int ch, int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      if (out_pulse[ch]) begin at = cyc; return; end
      @(negedge clk);
    end
  endtask
  task automatic count_high(int ch, int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      hi += int'(out_pulse[ch]);
      @(negedge clk);
    end
  endtask
  int first_rise[NUM_CH];
  task automatic run_watch(int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) if (out_pulse[i] && first_rise[i] < 0) first_rise[i] = cyc;
    end
  endtask
  initial begin
    int t, at, hi, hi2, d;
    reset = 1'b1; trig_in = '0;
    cfg.cfg_we = 1'b0; cfg.cfg_ch = '0; cfg.cfg_addr = '0; cfg.cfg_data = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("reset_out_pulse", int'(out_pulse), 0);
    chk("reset_busy", int'(busy), 0);
    // single edge: N=1 D=5 W=2 rising -> pulse at t+8 for 2 cycles
    setup(0, 1, 5, 2, 1);
    tick(3);
    trig_in[0] = 1'b1; t = cyc + 1;
    wait_rise(0, 40, at);
    chk("single_rise_offset", at - t, 8);
    count_high(0, 8, hi);
    chk("single_width", hi, 2);
    trig_in[0] = 1'b0;
    // edge count: ch1 N=3 D=0 W=1 falling
    trig_in[1] = 1'b1;
    tick(4);
    setup(1, 3, 0, 1, 3);
    tick(3);
    hi2 = 0;
    repeat (2) begin
      trig_in[1] = 1'b0; count_high(1, 4, hi); hi2 += hi;
      trig_in[1] = 1'b1; count_high(1, 4, hi); hi2 += hi;
    end
    chk("count_early_pulses", hi2, 0);
    trig_in[1] = 1'b0; t = cyc + 1;
    wait_rise(1, 20, at);
    chk("count_rise_offset", at - t, 3);
    count_high(1, 6, hi);
    chk("count_width", hi, 1);
    // re-arm / miss: second edge during DELAY is not a retrigger
    setup(2, 1, 100, 4, 1);
    tick(2);
    trig_in[2] = 1'b1; tick(10);
    trig_in[2] = 1'b0; tick(10);
    trig_in[2] = 1'b1;
    count_high(2, 140, hi);
    chk("rearm_high_cycles", hi, 4);
`ifdef SHIFTER_MISS_CNT_EN
    chk("rearm_miss", int'(miss_cnt[2*MISS_W +: MISS_W]), 1);
`endif
    trig_in[2] = 1'b0;
    // shadowing: DELAY write while busy applies to the next trigger
    setup(3, 1, 10, 2, 1);
    tick(2);
    trig_in[3] = 1'b1; t = cyc + 1;
    tick(4);
    wr(3, REG_DELAY, 50);
    wait_rise(3, 40, at);
    chk("shadow_first_offset", at - t, 13);
    trig_in[3] = 1'b0; tick(10);
    trig_in[3] = 1'b1; t = cyc + 1;
    wait_rise(3, 100, at);
    chk("shadow_second_offset", at - t, 53);
    trig_in[3] = 1'b0;
    // disable in the 5th pulse cycle of a 20-cycle pulse
    wr(0, REG_DELAY, 0); wr(0, REG_WIDTH, 20);
    tick(2);
    trig_in[0] = 1'b1;
    wait_rise(0, 20, at);
    tick(4);
    wr(0, REG_CTRL, 0);
    chk("disable_pulse_low", int'(out_pulse[0]), 0);
    chk("disable_busy_low", int'(busy[0]), 0);
    trig_in[0] = 1'b0; tick(3);
    trig_in[0] = 1'b1;
    count_high(0, 15, hi);
    chk("disabled_no_pulse", hi, 0);
    trig_in = '0;
    tick(5);
    // independence: ch i uses N=i+1 D=3i+2 W=i+1, edges every 6 cycles on all channels
    for (int i = 0; i < NUM_CH; i++) begin
      setup(i, i + 1, 3 * i + 2, i + 1, 1);
      first_rise[i] = -1;
    end
    tick(3);
    t = cyc + 1;
    repeat (4) begin
      trig_in = '1; run_watch(3);
      trig_in = '0; run_watch(3);
    end
    run_watch(30);
    for (int i = 0; i < NUM_CH; i++) chk($sformatf("indep_rise_ch%0d", i), first_rise[i] - t, 9 * i + 5);
    // reset in the middle of DELAY, then confirm reset register values (D=0 N=1 W=1)
    wr(0, REG_DELAY, 40); wr(0, REG_CTRL, 1);
    tick(2);
    trig_in[0] = 1'b1; tick(6);
    chk("pre_reset_busy", int'(busy[0]), 1);
    reset = 1'b1; tick(1);
    chk("mid_reset_out_pulse", int'(out_pulse), 0);
    chk("mid_reset_busy", int'(busy), 0);
    tick(1); reset = 1'b0;
    trig_in[0] = 1'b0;
    wr(0, REG_CTRL, 1);
    tick(4);
    trig_in[0] = 1'b1; t = cyc + 1;
    wait_rise(0, 20, at);
    chk("post_reset_offset", at - t, 3);
    count_high(0, 5, hi);
    chk("post_reset_width", hi, 1);
    // randomized traffic
    for (int i = 0; i < NUM_CH; i++) setup(i, $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(0, 1) | 1);
    for (int k = 0; k < 4000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 7) begin
        case ($urandom_range(0, 3))
          0: wr($urandom_range(0, 3), REG_DELAY, $urandom_range(0, 20) | ($urandom & 32'hFF00_0000));
          1: wr($urandom_range(0, 3), REG_EVENT, $urandom_range(0, 4) | ($urandom & 32'hFFFF_FC00));
          2: wr($urandom_range(0, 3), REG_WIDTH, $urandom_range(0, 8) | ($urandom & 32'hFFFF_0000));
          default: begin
            d = (($urandom_range(0, 4) != 0) ? 1 : 0) | ($urandom_range(0, 1) << 1);
            wr($urandom_range(0, 3), REG_CTRL, d | ($urandom & 32'hFFFF_FFFC));
          end
        endcase
      end else if (r == 7 && $urandom_range(0, 15) == 0) begin
        reset = 1'b1; tick(1); reset = 1'b0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) if ($urandom_range(0, 5) == 0) trig_in[i] = ~trig_in[i];
        tick(1);
      end
    end
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
